// File: rtl/jtframe_dlrx_pkg.sv
// Shared constants for the SPI download receiver: FSM state codes,
// data_io command bytes and the default ioctl address width.
package jtframe_dlrx_pkg;

    localparam int DLRX_AW = 22;

    localparam logic [7:0] DLRX_CMD_TX  = 8'h53;
    localparam logic [7:0] DLRX_CMD_DAT = 8'h54;
    localparam logic [7:0] DLRX_CMD_IDX = 8'h55;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_IDX   = 3'd2;
    localparam logic [2:0] ST_TXCTL = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_SKIP  = 3'd5;

endpackage

// File: rtl/jtframe_spi_byte.sv
// SPI byte assembler running in the clk domain. SCK, SS2 and DI are
// synchronized through matching 2-flop chains so DI lines up with the
// SCK edge seen by the detector. A byte in progress is thrown away
// whenever the chip select goes inactive, even on the 8th edge.
module jtframe_spi_byte (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_ss2,
    input  logic       spi_di,
    output logic       frame_active,
    output logic       byte_vld,
    output logic [7:0] rx_byte
);

    logic       sck_m, sck_s1, sck_s2;
    logic       ss_m, ss_s1;
    logic       di_m, di_s1;
    logic [6:0] shifter;
    logic [2:0] bit_cnt;
    logic       sck_rise;

    assign sck_rise     = sck_s1 & ~sck_s2;
    assign frame_active = ~ss_s1;

    // Two-stage synchronizers plus one extra SCK stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_m  <= 1'b0;
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            ss_m   <= 1'b1;
            ss_s1  <= 1'b1;
            di_m   <= 1'b0;
            di_s1  <= 1'b0;
        end else begin
            sck_m  <= spi_sck;
            sck_s1 <= sck_m;
            sck_s2 <= sck_s1;
            ss_m   <= spi_ss2;
            ss_s1  <= ss_m;
            di_m   <= spi_di;
            di_s1  <= di_m;
        end
    end

    // Shift MSB-first on each SCK rise; chip select release wins over a completing byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifter  <= 7'd0;
            bit_cnt  <= 3'd0;
            byte_vld <= 1'b0;
            rx_byte  <= 8'd0;
        end else begin
            byte_vld <= 1'b0;
            if (ss_s1) begin
                shifter <= 7'd0;
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                shifter <= {shifter[5:0], di_s1};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_vld <= 1'b1;
                    rx_byte  <= {shifter, di_s1};
                end
            end
        end
    end

endmodule

// File: rtl/jtframe_spi_dlrx.sv
// SPI ROM-download receiver: decodes the data_io command stream and
// produces the byte-wide ioctl write port for the SDRAM prog interface.
// Optional macro JTFRAME_DLRX_CHECKSUM_EN adds dl_sum, a 16-bit wrapping
// sum of all bytes written during the current/last download.
module jtframe_spi_dlrx
    import jtframe_dlrx_pkg::*;
#(
    parameter int         AW      = DLRX_AW,
    parameter logic [7:0] CMD_TX  = DLRX_CMD_TX,
    parameter logic [7:0] CMD_DAT = DLRX_CMD_DAT,
    parameter logic [7:0] CMD_IDX = DLRX_CMD_IDX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SPI_SCK,
    input  logic          SPI_SS2,
    input  logic          SPI_DI,
    output logic          downloading,
    output logic [7:0]    ioctl_index,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_data,
    output logic          ioctl_wr,
`ifdef JTFRAME_DLRX_CHECKSUM_EN
    output logic [15:0]   dl_sum,
`endif
    output logic          ioctl_ovf
);

    logic       frame_active;
    logic       byte_vld;
    logic [7:0] rx_byte;
    logic [2:0] state;
    logic       first_wr;

    jtframe_spi_byte u_byte (
        .clk          (clk),
        .rst          (rst),
        .spi_sck      (SPI_SCK),
        .spi_ss2      (SPI_SS2),
        .spi_di       (SPI_DI),
        .frame_active (frame_active),
        .byte_vld     (byte_vld),
        .rx_byte      (rx_byte)
    );

    // Command FSM and ioctl registers; the address advances ahead of each write except the first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            downloading <= 1'b0;
            ioctl_index <= 8'd0;
            ioctl_addr  <= '0;
            ioctl_data  <= 8'd0;
            ioctl_wr    <= 1'b0;
            ioctl_ovf   <= 1'b0;
            first_wr    <= 1'b0;
`ifdef JTFRAME_DLRX_CHECKSUM_EN
            dl_sum      <= 16'd0;
`endif
        end else begin
            ioctl_wr <= 1'b0;
            if (!frame_active) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_CMD;
                    ST_CMD: if (byte_vld) begin
                        case (rx_byte)
                            CMD_IDX: state <= ST_IDX;
                            CMD_TX:  state <= ST_TXCTL;
                            CMD_DAT: state <= ST_DATA;
                            default: state <= ST_SKIP;
                        endcase
                    end
                    ST_IDX: if (byte_vld) begin
                        ioctl_index <= rx_byte;
                        state       <= ST_SKIP;
                    end
                    ST_TXCTL: if (byte_vld) begin
                        if (rx_byte != 8'd0) begin
                            downloading <= 1'b1;
                            ioctl_addr  <= '0;
                            ioctl_ovf   <= 1'b0;
                            first_wr    <= 1'b1;
`ifdef JTFRAME_DLRX_CHECKSUM_EN
                            dl_sum      <= 16'd0;
`endif
                        end else begin
                            downloading <= 1'b0;
                        end
                        state <= ST_SKIP;
                    end
                    ST_DATA: if (byte_vld) begin
                        ioctl_data <= rx_byte;
                        if (downloading) begin
                            ioctl_wr <= 1'b1;
`ifdef JTFRAME_DLRX_CHECKSUM_EN
                            dl_sum   <= dl_sum + {8'd0, rx_byte};
`endif
                            if (first_wr) begin
                                first_wr <= 1'b0;
                            end else begin
                                ioctl_addr <= ioctl_addr + 1'b1;
                                if (&ioctl_addr) ioctl_ovf <= 1'b1;
                            end
                        end
                    end
                    ST_SKIP: state <= ST_SKIP;
                    default: state <= ST_SKIP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_spi_dlrx.sv
// Self-checking bench for jtframe_spi_dlrx. Two instances share the SPI
// pins: one with the default 22-bit address and one with AW=4 so address
// wrap and the overflow flag are reachable. Expected behaviour comes from
// a frame-level model that counts writes since the last download start.
module tb_jtframe_spi_dlrx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic SPI_SCK = 1'b0;
    logic SPI_SS2 = 1'b1;
    logic SPI_DI  = 1'b0;

    logic        a_dl, b_dl;
    logic [7:0]  a_index, b_index;
    logic [21:0] a_addr;
    logic [3:0]  b_addr;
    logic [7:0]  a_data, b_data;
    logic        a_wr, b_wr;
    logic        a_ovf, b_ovf;
`ifdef JTFRAME_DLRX_CHECKSUM_EN
    logic [15:0] a_sum, b_sum;
`endif

    always #5 clk = ~clk;

    jtframe_spi_dlrx dut_a (
        .clk(clk), .rst(rst), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
        .downloading(a_dl), .ioctl_index(a_index), .ioctl_addr(a_addr),
        .ioctl_data(a_data), .ioctl_wr(a_wr),
`ifdef JTFRAME_DLRX_CHECKSUM_EN
        .dl_sum(a_sum),
`endif
        .ioctl_ovf(a_ovf)
    );

    jtframe_spi_dlrx #(.AW(4)) dut_b (
        .clk(clk), .rst(rst), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
        .downloading(b_dl), .ioctl_index(b_index), .ioctl_addr(b_addr),
        .ioctl_data(b_data), .ioctl_wr(b_wr),
`ifdef JTFRAME_DLRX_CHECKSUM_EN
        .dl_sum(b_sum),
`endif
        .ioctl_ovf(b_ovf)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_dl;
    logic [7:0]  m_index;
    logic [7:0]  m_data;
    int          m_n;
    logic [15:0] m_sum;
    int          exp_n[$];
    logic [7:0]  exp_data[$];
    int          rd_a = 0;
    int          rd_b = 0;
    logic [7:0]  frame_q[$];
    logic        a_wr_d = 1'b0;
    logic        b_wr_d = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_dl    = 1'b0;
        m_index = 8'd0;
        m_data  = 8'd0;
        m_n     = 0;
        m_sum   = 16'd0;
        exp_n.delete();
        exp_data.delete();
        rd_a = 0;
        rd_b = 0;
    endfunction

    // Apply the data_io rules to the whole bytes of one frame
    function automatic void model_frame(input bit drop_last);
        int nb;
        nb = frame_q.size() - (drop_last ? 1 : 0);
        if (nb < 1) return;
        if (frame_q[0] == 8'h55) begin
            if (nb >= 2) m_index = frame_q[1];
        end else if (frame_q[0] == 8'h53) begin
            if (nb >= 2) begin
                if (frame_q[1] != 8'd0) begin
                    m_dl  = 1'b1;
                    m_n   = 0;
                    m_sum = 16'd0;
                end else begin
                    m_dl = 1'b0;
                end
            end
        end else if (frame_q[0] == 8'h54) begin
            for (int i = 1; i < nb; i++) begin
                m_data = frame_q[i];
                if (m_dl) begin
                    exp_n.push_back(m_n);
                    exp_data.push_back(frame_q[i]);
                    m_n++;
                    m_sum = m_sum + 16'(frame_q[i]);
                end
            end
        end
    endfunction

    function automatic int exp_addr(input int aw);
        return (m_n == 0) ? 0 : (m_n - 1) % (1 << aw);
    endfunction

    // Check every write strobe against the expected write list
    always @(negedge clk) begin
        if (rst) begin
            a_wr_d = 1'b0;
            b_wr_d = 1'b0;
        end else begin
            if (a_wr) begin
                if (a_wr_d) checkOutput("a_wr_consecutive", 32'd1, 32'd0);
                if (rd_a < exp_data.size()) begin
                    checkOutput("a_wr_data", 32'(a_data), 32'(exp_data[rd_a]));
                    checkOutput("a_wr_addr", 32'(a_addr), 32'(exp_n[rd_a] % (1 << 22)));
                end else begin
                    checkOutput("a_wr_unexpected", 32'd1, 32'd0);
                end
                rd_a++;
            end
            if (b_wr) begin
                if (b_wr_d) checkOutput("b_wr_consecutive", 32'd1, 32'd0);
                if (rd_b < exp_data.size()) begin
                    checkOutput("b_wr_data", 32'(b_data), 32'(exp_data[rd_b]));
                    checkOutput("b_wr_addr", 32'(b_addr), 32'(exp_n[rd_b] % 16));
                    checkOutput("b_wr_ovf", 32'(b_ovf), 32'(exp_n[rd_b] >= 16));
                end else begin
                    checkOutput("b_wr_unexpected", 32'd1, 32'd0);
                end
                rd_b++;
            end
            a_wr_d = a_wr;
            b_wr_d = b_wr;
        end
    end

    // Send frame_q on the SPI pins; optionally extra partial bits or SS2 rising with the last edge
    task automatic applyStimulus(input int partial_bits, input bit coincide);
        model_frame(coincide);
        SPI_SS2 = 1'b0;
        #100;
        for (int i = 0; i < frame_q.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                SPI_DI = frame_q[i][b];
                #50;
                SPI_SCK = 1'b1;
                if (coincide && i == frame_q.size() - 1 && b == 0) SPI_SS2 = 1'b1;
                #50;
                SPI_SCK = 1'b0;
            end
            #($urandom_range(0, 30));
        end
        for (int p = 0; p < partial_bits; p++) begin
            SPI_DI = 1'($urandom);
            #50;
            SPI_SCK = 1'b1;
            #50;
            SPI_SCK = 1'b0;
        end
        #50;
        SPI_SS2 = 1'b1;
        #200;
    endtask

    task automatic send(input int partial_bits, input bit coincide);
        applyStimulus(partial_bits, coincide);
        check_state();
    endtask

    task automatic check_state();
        checkOutput("a_downloading", 32'(a_dl), 32'(m_dl));
        checkOutput("b_downloading", 32'(b_dl), 32'(m_dl));
        checkOutput("a_index", 32'(a_index), 32'(m_index));
        checkOutput("b_index", 32'(b_index), 32'(m_index));
        checkOutput("a_data", 32'(a_data), 32'(m_data));
        checkOutput("a_addr", 32'(a_addr), 32'(exp_addr(22)));
        checkOutput("b_addr", 32'(b_addr), 32'(exp_addr(4)));
        checkOutput("a_ovf", 32'(a_ovf), 32'd0);
        checkOutput("b_ovf", 32'(b_ovf), 32'(m_n > 16));
        checkOutput("a_wr_count", 32'(rd_a), 32'(exp_data.size()));
        checkOutput("b_wr_count", 32'(rd_b), 32'(exp_data.size()));
`ifdef JTFRAME_DLRX_CHECKSUM_EN
        checkOutput("a_sum", 32'(a_sum), 32'(m_sum));
        checkOutput("b_sum", 32'(b_sum), 32'(m_sum));
`endif
    endtask

    task automatic check_zero(input string tag);
        checkOutput({tag, "_a_outs"}, {a_dl, a_wr, a_ovf, a_index, a_data}, 32'd0);
        checkOutput({tag, "_a_addr"}, 32'(a_addr), 32'd0);
        checkOutput({tag, "_b_outs"}, {b_dl, b_wr, b_ovf, b_index, b_data}, 32'd0);
        checkOutput({tag, "_b_addr"}, 32'(b_addr), 32'd0);
`ifdef JTFRAME_DLRX_CHECKSUM_EN
        checkOutput({tag, "_sums"}, {a_sum, b_sum}, 32'd0);
`endif
    endtask

    initial begin
        int kind;
        int len;
        model_reset();
        #23;
        check_zero("reset");
        rst = 1'b0;
        #50;

        // Index frame
        frame_q = '{8'h55, 8'h03};
        send(0, 1'b0);
        checkOutput("index_03", 32'(a_index), 32'h03);

        // Start, three data bytes, stop
        frame_q = '{8'h53, 8'h01};
        send(0, 1'b0);
        checkOutput("dl_started", 32'(a_dl), 32'd1);
        frame_q = '{8'h54, 8'hA5, 8'h5A, 8'hFF};
        send(0, 1'b0);
        frame_q = '{8'h53, 8'h00};
        send(0, 1'b0);
        checkOutput("dl_stopped", 32'(a_dl), 32'd0);
        checkOutput("three_writes", 32'(rd_a), 32'd3);
`ifdef JTFRAME_DLRX_CHECKSUM_EN
        checkOutput("sum_01fe", 32'(a_sum), 32'h01FE);
`endif

        // Partial byte aborted by SS2, then one more byte
        frame_q = '{8'h53, 8'h01};
        send(0, 1'b0);
        frame_q = '{8'h54, 8'h10, 8'h22};
        send(5, 1'b0);
        frame_q = '{8'h54, 8'h11};
        send(0, 1'b0);
        checkOutput("after_partial_addr", 32'(a_addr), 32'd2);

        // SS2 rise coinciding with the 8th edge discards that byte
        frame_q = '{8'h54, 8'h33, 8'h44};
        send(0, 1'b1);
        checkOutput("coincide_data", 32'(a_data), 32'h33);

        // 17 bytes from a fresh start wrap the AW=4 instance
        frame_q = '{8'h53, 8'h01};
        send(0, 1'b0);
        frame_q = '{8'h54};
        for (int i = 0; i < 17; i++) frame_q.push_back(8'($urandom));
        send(0, 1'b0);
        checkOutput("wrap_b_addr", 32'(b_addr), 32'd0);
        checkOutput("wrap_b_ovf", 32'(b_ovf), 32'd1);
        checkOutput("wrap_a_addr", 32'(a_addr), 32'd16);

        // No strobes while stopped or after an unknown command
        frame_q = '{8'h53, 8'h00};
        send(0, 1'b0);
        frame_q = '{8'h54, 8'h77};
        send(0, 1'b0);
        frame_q = '{8'h99, 8'h54, 8'h88};
        send(0, 1'b0);
        checkOutput("stopped_data", 32'(a_data), 32'h77);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            kind = int'($urandom_range(0, 5));
            len  = int'($urandom_range(1, 6));
            frame_q.delete();
            case (kind)
                0: begin
                    frame_q.push_back(8'h53);
                    frame_q.push_back(($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                end
                4: begin
                    frame_q.push_back(8'h55);
                    frame_q.push_back(8'($urandom));
                end
                5: begin
                    frame_q.push_back(8'($urandom));
                    frame_q.push_back(8'($urandom));
                end
                default: begin
                    frame_q.push_back(8'h54);
                    for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
                end
            endcase
            if ($urandom_range(0, 3) == 0) send(0, 1'b1);
            else send(int'($urandom_range(0, 7)), 1'b0);
        end

        // Reset in the middle of a data byte during a download
        frame_q = '{8'h53, 8'h01};
        send(0, 1'b0);
        frame_q = '{8'h54, 8'h5C};
        send(0, 1'b0);
        SPI_SS2 = 1'b0;
        #100;
        for (int b = 0; b < 11; b++) begin
            SPI_DI = 1'($urandom);
            #50;
            SPI_SCK = 1'b1;
            #50;
            SPI_SCK = 1'b0;
        end
        #3;
        rst = 1'b1;
        #1;
        check_zero("midreset");
        model_reset();
        SPI_SS2 = 1'b1;
        #100;
        rst = 1'b0;
        #50;
        frame_q = '{8'h53, 8'h01};
        send(0, 1'b0);
        frame_q = '{8'h54, 8'hC3};
        send(0, 1'b0);
        checkOutput("restart_addr", 32'(a_addr), 32'd0);
        checkOutput("restart_data", 32'(a_data), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtframe_spi_dlrx.md
Name: jtframe_spi_dlrx

Overview:
- Synthesizable SPI download receiver: the receiving end of the ROM-download SPI stream produced by the simulation SPI transmitter and by the MiST firmware.
- Runs entirely in the SDRAM clock domain. Oversamples SCK/SS/DI, decodes the data_io command protocol, and emits a byte-wide ioctl write stream (addr/data/wr) plus a downloading flag that feed the SDRAM controller's prog port.
- Replaces the dual-clock data_io for both simulation and synthesis.

Parameters:
- AW, 22: ioctl_addr width; address wraps at 2^AW.
- CMD_TX, 8'h53: file-transfer control command.
- CMD_DAT, 8'h54: file-data command.
- CMD_IDX, 8'h55: file-index command.

Ports:
- clk  in  1  SDRAM clock (96 MHz); SCK half-period is at least 4 clk.
- rst  in  1  reset.
- SPI_SCK  in  1  SPI clock, asynchronous to clk.
- SPI_SS2  in  1  chip select, active low, asynchronous.
- SPI_DI  in  1  serial data, MSB first, sampled on SCK rising edge.
- downloading  out  1  high while a download is active.
- ioctl_index  out  8  last received file index.
- ioctl_addr  out  AW  byte address of the current or last write.
- ioctl_data  out  8  byte being written.
- ioctl_wr  out  1  one-clk write strobe.
- ioctl_ovf  out  1  sticky: address wrapped during the current download.

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst is asynchronous and active-high. On reset, every output is 0 and the FSM is in IDLE.
- Input synchronization: SCK, SS2 and DI each pass through a 2-flop synchronizer. A SCK rising edge is detected on the synced signal (sck_s1 & ~sck_s2). DI is taken from the same synchronizer stage as SCK, so there is no skew between them.
- Shift register: an 8-bit shifter with a 3-bit bit counter runs while SS2 (synced) is low. On the 8th bit, byte_vld pulses for 1 clk with the assembled byte.
- Latency: ioctl_wr rises 4 clk (±1 from sampling phase) after the raw SCK edge of the last bit of a data byte.
- FSM:
  - IDLE: waits for SS2 low, then goes to CMD.
  - CMD: first byte of the frame.
    - CMD_IDX goes to IDX.
    - CMD_TX goes to TXCTL.
    - CMD_DAT goes to DATA.
    - Any other byte goes to SKIP.
  - IDX: next byte is latched into ioctl_index, then SKIP.
  - TXCTL: next byte nonzero sets downloading=1, ioctl_addr=0, ioctl_ovf=0 and first_wr=1. Next byte zero clears downloading. Either way, then SKIP.
  - DATA: each byte drives ioctl_data<=byte and ioctl_wr<=downloading.
    - The address advances before the write, except on the first write after start, which uses address 0.
    - So ioctl_addr holds the written byte's address while ioctl_wr is high.
    - DATA stays active for further bytes.
  - SKIP: ignores all bytes until SS2 goes high.
- SS2 high in any state: the bit counter and shifter clear, any partial byte is discarded, and the FSM returns to IDLE. downloading, ioctl_index and ioctl_addr are held.
- Data received while downloading=0: ioctl_data updates, no strobe is issued, and the address does not change.
- Address wrap: incrementing from 2^AW-1 gives 0 and sets ioctl_ovf=1.
- ioctl_wr never asserts on two consecutive clk cycles.
- Simultaneous SS2 rise and 8th-bit edge: the SS2 rise wins and the byte is discarded.
- rst asserted mid-download: downloading drops immediately and no further strobes are issued.

Optional Feature:
- Macro: JTFRAME_DLRX_CHECKSUM_EN.
- When defined: adds output dl_sum[15:0], a 16-bit wrapping sum of every byte written with ioctl_wr=1. It clears when a download starts and is held after it ends, so the testbench can compare it with the ROM file's sum.
- When undefined: the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package jtframe_dlrx_pkg holds:
  - the FSM state enum (IDLE, CMD, IDX, TXCTL, DATA, SKIP);
  - command constants 8'h53, 8'h54, 8'h55;
  - the default AW.
- One sub-module, jtframe_spi_byte: synchronizers, edge detect, shifter and bit counter, producing byte_vld, byte and frame_active. The FSM and ioctl registers live in the top module.

Test Plan:
- Frame {55,03}: ioctl_index=8'h03; no ioctl_wr and downloading stays 0.
- Frame {53,01}, then frame {54,A5,5A,FF}, then frame {53,00}:
  - downloading rises after the first frame;
  - three wr strobes at addr 0,1,2 with data A5,5A,FF;
  - downloading falls after the last frame;
  - with the macro defined, dl_sum=16'h01FE.
- SS2 raised after 5 bits of a data byte, then a new frame {54,11}: no write for the partial byte; next write is addr+1 with data 11; no gap or duplicate.
- AW=4 override with 17 data bytes: addresses 0..15 then 0, and ioctl_ovf=1 on the 17th strobe.
- Frame {54,77} with downloading=0, and frame {99,54,88}: zero ioctl_wr strobes in both cases.
- Reset pulse mid data byte during a download: all outputs 0 within 1 clk, FSM in IDLE; a new {53,01} restarts at addr 0.
